// File: rtl/prng_pkg.sv
// Shared definitions for the 32-bit LFSR nibble generator and its stream
// checker. Both sides must agree on the width, the tap set and the number of
// nibbles needed to rebuild a full generator state.
//
// Contents:
//   LFSR_W, NIB_W, SYNC_NIBS  geometry of the stream
//   TAP_A..TAP_D              feedback taps {31,21,1,0}
//   state_e                   checker state {SYNC, TRACK}
//   lfsr_fb()                 next stream bit from a 32-bit window/state
package prng_pkg;

   localparam int LFSR_W    = 32;
   localparam int NIB_W     = 4;
   localparam int SYNC_NIBS = LFSR_W / NIB_W;

   localparam int TAP_A = 31;
   localparam int TAP_B = 21;
   localparam int TAP_C = 1;
   localparam int TAP_D = 0;

   typedef enum logic {
      SYNC  = 1'b0,
      TRACK = 1'b1
   } state_e;

   // Bit 0 of the window is the newest stream bit, bit 31 the oldest, so the
   // taps read b[n-1], b[n-2], b[n-22] and b[n-32].
   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
   endfunction

endpackage

// File: rtl/prng_nib_predict.sv
// Combinational predictor: from the last 32 stream bits, produce the next
// nibble the generator will emit and the window after those 4 bits.
//
// Ports:
//   window      in   last 32 stream bits, bit 0 newest
//   pred        out  predicted nibble, pred[0] is the earliest bit
//   window_nxt  out  window advanced by the 4 predicted bits
module prng_nib_predict
   import prng_pkg::*;
(
   input  logic [LFSR_W-1:0] window,
   output logic [NIB_W-1:0]  pred,
   output logic [LFSR_W-1:0] window_nxt
);

   logic [LFSR_W-1:0] w;

   // Each predicted bit feeds the next prediction, exactly as the generator
   // shifts one bit at a time.
   always_comb begin
      pred = '0;
      w    = window;
      for (int i = 0; i < NIB_W; i++) begin
         pred[i] = lfsr_fb(w);
         w       = {w[LFSR_W-2:0], pred[i]};
      end
      window_nxt = w;
   end

endmodule

// File: rtl/prng_stream_checker.sv
// Receive-side checker for the LFSR nibble generator. Rebuilds the generator
// state from the first 8 captured nibbles (SYNC), then predicts every further
// nibble and counts matches and mismatches (TRACK). ERR_LIMIT consecutive
// mismatches drop back to SYNC.
//
// Handshake: a nibble is taken on the first cycle of a din_done high level
// while ena is high (ena & din_done & !done_q); done_q follows din_done every
// cycle regardless of ena, so a level already high when ena rises is ignored.
//
// Ports:
//   clk, res_n      clock (rising) and asynchronous active-low reset
//   ena             capture enable
//   din, din_done   nibble (din[0] earliest) and generator done level
//   clr             synchronous clear of counters and err (state kept)
//   locked          high while in TRACK
//   err             one-cycle pulse after a mismatched capture
//   err_cnt         saturating count of mismatched nibbles
//   good_cnt        saturating count of matched nibbles
//   state_dbg       current checker state
module prng_stream_checker
   import prng_pkg::*;
#(
   parameter int ERR_LIMIT = 3,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             ena,
   input  logic [NIB_W-1:0] din,
   input  logic             din_done,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] good_cnt,
   output state_e           state_dbg
);

   localparam int FILL_W = $clog2(SYNC_NIBS);

   state_e              state, state_n;
   logic [FILL_W-1:0]   fill, fill_n;
   logic [3:0]          miss, miss_n;
   logic [LFSR_W-1:0]   window, window_n, sync_win, pred_win;
   logic [NIB_W-1:0]    pred;
   logic                done_q, cap;
   logic                err_q, err_set, ec_inc, gc_inc;
   logic [CNT_W-1:0]    err_cnt_q, good_cnt_q;

   assign cap = ena & din_done & ~done_q;

   prng_nib_predict u_predict (
      .window     (window),
      .pred       (pred),
      .window_nxt (pred_win)
   );

   // Received nibble shifted into the window in stream order (used in SYNC).
   always_comb begin
      sync_win = window;
      for (int i = 0; i < NIB_W; i++) begin
         sync_win = {sync_win[LFSR_W-2:0], din[i]};
      end
   end

   // State register plus the datapath that moves with it.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state  <= SYNC;
         fill   <= '0;
         miss   <= '0;
         window <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         fill   <= fill_n;
         miss   <= miss_n;
         window <= window_n;
         done_q <= din_done;
      end
   end

   // Next-state and capture decode.
   always_comb begin
      state_n  = state;
      fill_n   = fill;
      miss_n   = miss;
      window_n = window;
      err_set  = 1'b0;
      ec_inc   = 1'b0;
      gc_inc   = 1'b0;
      if (cap) begin
         case (state)
            SYNC: begin
               window_n = sync_win;
               if (fill == FILL_W'(SYNC_NIBS - 1)) begin
                  state_n = TRACK;
                  fill_n  = '0;
               end else begin
                  fill_n = fill + 1'b1;
               end
            end
            TRACK: begin
               // Advance on the prediction so a single bad nibble cannot
               // desynchronise the window.
               window_n = pred_win;
               if (din == pred) begin
                  gc_inc = 1'b1;
                  miss_n = '0;
               end else begin
                  err_set = 1'b1;
                  ec_inc  = 1'b1;
                  if (miss == 4'(ERR_LIMIT - 1)) begin
                     state_n = SYNC;
                     fill_n  = '0;
                     miss_n  = '0;
                  end else begin
                     miss_n = miss + 1'b1;
                  end
               end
            end
            default: state_n = SYNC;
         endcase
      end
   end

   // Counters and err pulse; clr overrides any increment in the same cycle.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         good_cnt_q <= '0;
      end else if (clr) begin
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         good_cnt_q <= '0;
      end else begin
         err_q <= err_set;
         if (ec_inc && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
         if (gc_inc && (good_cnt_q != '1)) good_cnt_q <= good_cnt_q + 1'b1;
      end
   end

   // Outputs.
   always_comb begin
      locked    = (state == TRACK);
      state_dbg = state;
      err       = err_q;
      err_cnt   = err_cnt_q;
      good_cnt  = good_cnt_q;
   end

endmodule

// File: tb/tb_prng_stream_checker.sv
// Bench for prng_stream_checker: a stimulus process drives nibbles and pushes
// the expected {err, locked, err_cnt, good_cnt} per capture; a monitor pops
// and compares one cycle after each capture and checks err stays low otherwise.
module tb_prng_stream_checker;
   import prng_pkg::*;

   localparam int CW = 8;
   localparam int EW = 2 + 2 * CW;
   localparam logic [31:0] SEED = 32'h1846_9258;

   logic          clk;
   logic          res_n;
   logic          ena;
   logic [3:0]    din;
   logic          din_done;
   logic          clr;
   logic          locked;
   logic          err;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] good_cnt;
   state_e        state_dbg;

   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];

   logic [31:0]   gen_s;
   logic [CW-1:0] ec, gc;
   logic          prev_done, cap_seen;
   logic [3:0]    seed_nibs [8];

   prng_stream_checker #(.ERR_LIMIT(3), .CNT_W(CW)) dut (
      .clk       (clk),
      .res_n     (res_n),
      .ena       (ena),
      .din       (din),
      .din_done  (din_done),
      .clr       (clr),
      .locked    (locked),
      .err       (err),
      .err_cnt   (err_cnt),
      .good_cnt  (good_cnt),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got err=%0b locked=%0b err_cnt=%0d good_cnt=%0d, want err=%0b locked=%0b err_cnt=%0d good_cnt=%0d",
                  name, act[EW-1], act[EW-2], act[2*CW-1:CW], act[CW-1:0],
                  expv[EW-1], expv[EW-2], expv[2*CW-1:CW], expv[CW-1:0]);
      end
   endtask

   // Independent generator model: MSB shifted out first, feedback into bit 0.
   task automatic gen_nib(output logic [3:0] d);
      for (int i = 0; i < 4; i++) begin
         d[i]  = gen_s[31];
         gen_s = {gen_s[30:0], gen_s[31] ^ gen_s[21] ^ gen_s[1] ^ gen_s[0]};
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [3:0] d, input logic c, input logic e_err,
                       input logic e_lock, input logic [CW-1:0] e_ec, input logic [CW-1:0] e_gc);
      @(negedge clk);
      ena      = 1'b1;
      din      = d;
      din_done = 1'b1;
      clr      = c;
      exp_q.push_back({e_err, e_lock, e_ec, e_gc});
      @(negedge clk);
      din_done = 1'b0;
      clr      = 1'b0;
   endtask

   task automatic send_clean();
      logic [3:0] d;
      gen_nib(d);
      gc = sat(gc);
      send(d, 1'b0, 1'b0, 1'b1, ec, gc);
   endtask

   task automatic send_bad(input logic lock_after);
      logic [3:0] d;
      gen_nib(d);
      ec = sat(ec);
      send(d ^ 4'b0100, 1'b0, 1'b1, lock_after, ec, gc);
   endtask

   // Clean nibbles while in SYNC: the last one of a full fill locks.
   task automatic send_sync(input int n, input int lock_at);
      logic [3:0] d;
      for (int k = 0; k < n; k++) begin
         gen_nib(d);
         send(d, 1'b0, 1'b0, (k == lock_at), ec, gc);
      end
   endtask

   // Table-driven first fill from the seed; the model advances alongside.
   task automatic send_seed(input int first, input int last);
      logic [3:0] d;
      for (int k = first; k <= last; k++) begin
         gen_nib(d);
         send(seed_nibs[k], 1'b0, 1'b0, (k == 7), ec, gc);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, {err, locked, err_cnt, good_cnt}, '0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         prev_done <= 1'b0;
         cap_seen  <= 1'b0;
      end else begin
         cap_seen  <= ena & din_done & ~prev_done;
         prev_done <= din_done;
      end
   end

   always @(negedge clk) begin
      if (res_n) begin
         if (cap_seen) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL resp_underflow: got a capture response, want none queued");
            end else begin
               check("resp", {err, locked, err_cnt, good_cnt}, exp_q.pop_front());
            end
         end else begin
            total++;
            if (err !== 1'b0) begin
               bad++;
               $display("FAIL idle_err: got err=%0b, want 0", err);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      seed_nibs = '{4'h8, 4'h1, 4'h2, 4'h6, 4'h9, 4'h4, 4'hA, 4'h1};
      ena = 1'b0; din = '0; din_done = 1'b0; clr = 1'b0;
      res_n = 1'b1;
      #3 res_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      res_n = 1'b1;
      ec = '0; gc = '0;

      // Lock from the seed, then 100 matching nibbles.
      gen_s = SEED;
      send_seed(0, 7);
      for (int k = 0; k < 100; k++) send_clean();

      // Single flipped din[2]: one err, lock kept, good count resumes.
      send_bad(1'b1);
      send_clean();

      // Three consecutive mismatches drop lock; 8 clean nibbles relock.
      send_bad(1'b1);
      send_bad(1'b1);
      send_bad(1'b0);
      send_sync(8, 7);
      send_clean();

      // done held high 20 cycles: exactly one capture.
      begin
         logic [3:0] d;
         gen_nib(d);
         gc = sat(gc);
         @(negedge clk);
         ena = 1'b1; din = d; din_done = 1'b1;
         exp_q.push_back({1'b0, 1'b1, ec, gc});
         repeat (20) @(negedge clk);
         din_done = 1'b0;
      end
      // done pulse while ena low: ignored.
      @(negedge clk); ena = 1'b0; din = 4'hF; din_done = 1'b1;
      @(negedge clk); din_done = 1'b0;
      // done already high when ena rises: ignored.
      @(negedge clk); din = 4'h3; din_done = 1'b1;
      @(negedge clk); ena = 1'b1;
      repeat (3) @(negedge clk);
      din_done = 1'b0;
      send_clean();

      // Drop to SYNC, partial fill of 5, then async reset mid-cycle.
      send_bad(1'b1);
      send_bad(1'b1);
      send_bad(1'b0);
      send_sync(5, 99);
      @(posedge clk);
      #2 res_n = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk);
      check_zero("reset_hold");
      res_n = 1'b1;
      ec = '0; gc = '0;

      // Fresh fill from the seed with an ena-low done pulse in the middle.
      gen_s = SEED;
      send_seed(0, 2);
      @(negedge clk); ena = 1'b0; din = 4'hF; din_done = 1'b1;
      @(negedge clk); din_done = 1'b0;
      send_seed(3, 7);
      send_clean();

      // err_cnt saturation.
      for (int r = 0; r < 128; r++) begin
         send_bad(1'b1);
         send_bad(1'b1);
         send_clean();
      end
      send_bad(1'b1);

      // clr together with a capture: counters cleared, window still advances.
      begin
         logic [3:0] d;
         gen_nib(d);
         ec = '0; gc = '0;
         send(d, 1'b1, 1'b0, 1'b1, ec, gc);
      end
      send_clean();
      send_clean();

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover: got %0d pending responses, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
